// File: rtl/pp_pipeline_accel_quant_pkg.sv
// Shared widths, channel type and the round/shift/clamp helper
// for the quantise/saturate stage.
package pp_pipeline_accel_quant_pkg;

  localparam int DIN_W   = 32;
  localparam int BIAS_W  = 32;
  localparam int DOUT_W  = 8;
  localparam int SHIFT_W = 5;
  localparam int NUM_CH  = 3;
  localparam int SUM_W   = 34;

  typedef logic [1:0] ch_t;

  localparam ch_t CH_LAST = ch_t'(NUM_CH - 1);

  typedef struct packed {
    logic              clamped;
    logic [DOUT_W-1:0] pixel;
  } rs_res_t;

  function automatic rs_res_t round_shift_sat(
    input logic signed [SUM_W-1:0] sum,
    input logic [SHIFT_W-1:0]      sh,
    input logic                    sign_out
  );
    logic signed [SUM_W:0] rnd;
    logic signed [SUM_W:0] r;
    logic signed [SUM_W:0] hi;
    logic signed [SUM_W:0] lo;
    rs_res_t               res;
    rnd = '0;
    if (sh != '0)
      rnd = (SUM_W+1)'(1) <<< (sh - SHIFT_W'(1));
    r  = ($signed({sum[SUM_W-1], sum}) + rnd) >>> sh;
    hi = sign_out ? (SUM_W+1)'(127) : (SUM_W+1)'(255);
    lo = sign_out ? -(SUM_W+1)'(128) : '0;
    res.clamped = 1'b0;
    res.pixel   = r[DOUT_W-1:0];
    if (r > hi) begin
      res.clamped = 1'b1;
      res.pixel   = hi[DOUT_W-1:0];
    end else if (r < lo) begin
      res.clamped = 1'b1;
      res.pixel   = lo[DOUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/pp_pipeline_accel_quant_round_sat.sv
// Combinational round-half-up shift and clamp between the
// bias-add register and the output register.
module pp_pipeline_accel_quant_round_sat
  import pp_pipeline_accel_quant_pkg::*;
(
  input  logic signed [SUM_W-1:0] sum_i,
  input  logic [SHIFT_W-1:0]      sh_i,
  input  logic                    sign_i,
  output logic [DOUT_W-1:0]       pixel_o,
  output logic                    clamped_o
);

  rs_res_t res;

  // evaluate the shared helper on the S1 contents
  always_comb begin
    res       = round_shift_sat(sum_i, sh_i, sign_i);
    pixel_o   = res.pixel;
    clamped_o = res.clamped;
  end

endmodule

// File: rtl/pp_pipeline_accel_quant_sat_stage.sv
// Bias add, round shift and 8-bit saturate on a valid/ready stream.
// QUANT_SAT_STATS_EN adds sat_clr/sat_count clamp statistics.
module pp_pipeline_accel_quant_sat_stage
  import pp_pipeline_accel_quant_pkg::*;
(
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [DIN_W-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic [NUM_CH*BIAS_W-1:0] cfg_bias,
  input  logic                     cfg_sign_out,
`ifdef QUANT_SAT_STATS_EN
  input  logic                     sat_clr,
  output logic [15:0]              sat_count,
`endif
  output logic [DOUT_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);

  logic adv1, adv2, in_acc;
  logic [BIAS_W-1:0] bias_sel;

  logic              s1_valid_q, s1_valid_d;
  logic [SUM_W-1:0]  s1_sum_q, s1_sum_d;
  logic [SHIFT_W-1:0] s1_sh_q, s1_sh_d;
  logic              s1_sign_q, s1_sign_d;
  logic              s1_last_q, s1_last_d;
  ch_t               ch_q, ch_d;
  logic              out_valid_q, out_valid_d;
  logic [DOUT_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic [DOUT_W-1:0] rs_pixel;
  logic              rs_clamped;

  assign bias_sel  = cfg_bias[int'(ch_q)*BIAS_W +: BIAS_W];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  pp_pipeline_accel_quant_round_sat u_rs (
    .sum_i     ($signed(s1_sum_q)),
    .sh_i      (s1_sh_q),
    .sign_i    (s1_sign_q),
    .pixel_o   (rs_pixel),
    .clamped_o (rs_clamped)
  );

  // handshake, channel rotation and next-state of both stages
  always_comb begin
    adv2        = !out_valid_q || out_ready;
    adv1        = !s1_valid_q || adv2;
    in_acc      = in_valid && adv1;
    in_ready    = adv1;
    s1_valid_d  = s1_valid_q;
    s1_sum_d    = s1_sum_q;
    s1_sh_d     = s1_sh_q;
    s1_sign_d   = s1_sign_q;
    s1_last_d   = s1_last_q;
    ch_d        = ch_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sum_d  = {{(SUM_W-DIN_W){in_data[DIN_W-1]}}, in_data}
                  + {{(SUM_W-BIAS_W){bias_sel[BIAS_W-1]}}, bias_sel};
        s1_sh_d   = cfg_shift;
        s1_sign_d = cfg_sign_out;
        s1_last_d = in_last;
      end
    end
    if (in_acc)
      ch_d = (in_last || ch_q == CH_LAST) ? '0 : ch_q + ch_t'(1);
    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = rs_pixel;
        out_last_d = s1_last_q;
      end
    end
  end

  // pipeline state; reset drops any beats in flight
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_sh_q     <= '0;
      s1_sign_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      ch_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_sh_q     <= s1_sh_d;
      s1_sign_q   <= s1_sign_d;
      s1_last_q   <= s1_last_d;
      ch_q        <= ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef QUANT_SAT_STATS_EN
  logic        out_clamp_q, out_clamp_d;
  logic [15:0] sat_count_q, sat_count_d;

  assign sat_count = sat_count_q;

  // clamp flag follows its beat; count clamped handshakes
  always_comb begin
    out_clamp_d = out_clamp_q;
    if (adv2 && s1_valid_q)
      out_clamp_d = rs_clamped;
    sat_count_d = sat_count_q;
    if (sat_clr)
      sat_count_d = '0;
    else if (out_valid_q && out_ready && out_clamp_q &&
             sat_count_q != 16'hFFFF)
      sat_count_d = sat_count_q + 16'd1;
  end

  // statistics registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_clamp_q <= 1'b0;
      sat_count_q <= '0;
    end else begin
      out_clamp_q <= out_clamp_d;
      sat_count_q <= sat_count_d;
    end
  end
`else
  logic unused_clamped;
  assign unused_clamped = rs_clamped;
`endif

endmodule
